// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one RS232 transmitter
// between NUM_REQ byte producers. Latches the winning byte, launches it
// with a tx_start level handshake and tracks tx_busy until the frame ends.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic                       active,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       done,
  output logic                       timeout_err
);

  localparam int          OW = $clog2(NUM_REQ);
  localparam int          CW = $clog2(START_TIMEOUT + 1);
  localparam int unsigned NR = NUM_REQ;

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic [OW-1:0]        r_ptr, w_ptr_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0]   r_ack, w_ack_nxt;
  logic [7:0]           r_tx_data, w_tx_data_nxt;
  logic                 r_tx_start, w_tx_start_nxt;
  logic                 r_active, w_active_nxt;
  logic [OW-1:0]        r_owner, w_owner_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_timeout_err, w_timeout_err_nxt;

  logic                 w_any;
  logic [OW-1:0]        w_win;
  logic [OW-1:0]        w_idx;
  logic                 w_expire;
  logic [7:0]           w_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign w_bytes[g] = req_data[8*g +: 8];
  end

  // Last START cycle: START_TIMEOUT-1 edges already spent holding tx_start.
  assign w_expire = (r_cnt == CW'(START_TIMEOUT - 1));

  // Round-robin winner search starting just above the last grant.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int unsigned off = 1; off <= NR; off++) begin
      w_idx = OW'((32'(r_ptr) + off) % NR);
      if (!w_any && req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  // State register plus registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_ptr         <= OW'(NUM_REQ - 1);
      r_cnt         <= '0;
      r_ack         <= '0;
      r_tx_data     <= '0;
      r_tx_start    <= 1'b0;
      r_active      <= 1'b0;
      r_owner       <= '0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ptr         <= w_ptr_nxt;
      r_cnt         <= w_cnt_nxt;
      r_ack         <= w_ack_nxt;
      r_tx_data     <= w_tx_data_nxt;
      r_tx_start    <= w_tx_start_nxt;
      r_active      <= w_active_nxt;
      r_owner       <= w_owner_nxt;
      r_done        <= w_done_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  // Next-state logic; busy on the expiry edge wins over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (w_any) w_state_nxt = START;
      START: begin
        if (tx_busy)       w_state_nxt = WAIT_DONE;
        else if (w_expire) w_state_nxt = IDLE;
      end
      WAIT_DONE: if (!tx_busy) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and timeout counter.
  always_comb begin
    w_ptr_nxt         = r_ptr;
    w_cnt_nxt         = r_cnt;
    w_ack_nxt         = '0;
    w_tx_data_nxt     = r_tx_data;
    w_tx_start_nxt    = r_tx_start;
    w_active_nxt      = r_active;
    w_owner_nxt       = r_owner;
    w_done_nxt        = 1'b0;
    w_timeout_err_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_ack_nxt[w_win] = 1'b1;
          w_tx_data_nxt    = w_bytes[w_win];
          w_tx_start_nxt   = 1'b1;
          w_active_nxt     = 1'b1;
          w_owner_nxt      = w_win;
          w_ptr_nxt        = w_win;
          w_cnt_nxt        = '0;
        end
      end
      START: begin
        if (tx_busy) begin
          w_tx_start_nxt = 1'b0;
        end else if (w_expire) begin
          w_tx_start_nxt    = 1'b0;
          w_timeout_err_nxt = 1'b1;
          w_active_nxt      = 1'b0;
        end else if (r_cnt != CW'(START_TIMEOUT)) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          w_done_nxt   = 1'b1;
          w_active_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign ack         = r_ack;
  assign tx_data     = r_tx_data;
  assign tx_start    = r_tx_start;
  assign active      = r_active;
  assign owner       = r_owner;
  assign done        = r_done;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter with a small transmitter model.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        active;
  logic [1:0]  owner;
  logic        done;
  logic        timeout_err;

  // transmitter model controls
  logic        model_en;
  int          dly;
  int          busy_len;
  int          seen;
  int          bcnt;

  int          n_checks = 0;
  int          n_fail   = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .START_TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .active      (active),
    .owner       (owner),
    .done        (done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Transmitter: raises busy once tx_start has been seen for dly edges,
  // holds it busy_len cycles.
  always @(posedge clk) begin
    if (rst || !model_en) begin
      tx_busy <= 1'b0;
      seen    <= 0;
      bcnt    <= 0;
    end else if (tx_busy) begin
      if (bcnt <= 1) tx_busy <= 1'b0;
      bcnt <= bcnt - 1;
    end else if (tx_start) begin
      if (seen + 1 >= dly) begin
        tx_busy <= 1'b1;
        bcnt    <= busy_len;
        seen    <= 0;
      end else begin
        seen <= seen + 1;
      end
    end else begin
      seen <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ack(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (ack != 4'b0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (done) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_txlow(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (!tx_start) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack"},   32'(ack), 32'h0);
    chk({tag, "_data"},  32'(tx_data), 32'h0);
    chk({tag, "_start"}, 32'(tx_start), 32'h0);
    chk({tag, "_act"},   32'(active), 32'h0);
    chk({tag, "_own"},   32'(owner), 32'h0);
    chk({tag, "_done"},  32'(done), 32'h0);
    chk({tag, "_tmo"},   32'(timeout_err), 32'h0);
  endtask

  // Waits for a grant, checks it, then checks the ack pulse has ended.
  task automatic grant_chk(input string tag, input int idx, input logic [7:0] byt);
    bit ok;
    wait_ack(60, ok);
    chk({tag, "_seen"}, 32'(ok), 32'h1);
    chk({tag, "_ack"},  32'(ack), 32'(4'b1 << idx));
    chk({tag, "_data"}, 32'(tx_data), 32'(byt));
    chk({tag, "_own"},  32'(owner), 32'(idx));
    chk({tag, "_start"}, 32'(tx_start), 32'h1);
    chk({tag, "_act"},  32'(active), 32'h1);
    tick();
    chk({tag, "_ack1"}, 32'(ack), 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bit ok;
    int n;
    bit flag;
    rst = 1'b1; req = '0; req_data = '0;
    model_en = 1'b1; dly = 1; busy_len = 100;
    tick();
    do_reset();
    chk_reset_vals("rst");

    // single request
    req = 4'b0100; req_data = 32'h00A5_0000;
    tick();
    chk("s_ack",  32'(ack), 32'h4);
    chk("s_data", 32'(tx_data), 32'hA5);
    chk("s_own",  32'(owner), 32'h2);
    chk("s_start0", 32'(tx_start), 32'h1);
    chk("s_act",  32'(active), 32'h1);
    req = '0;
    tick();
    chk("s_ack1", 32'(ack), 32'h0);
    chk("s_start1", 32'(tx_start), 32'h1);
    tick();
    chk("s_start2", 32'(tx_start), 32'h0);
    chk("s_act2", 32'(active), 32'h1);
    wait_done(200, ok);
    chk("s_done_seen", 32'(ok), 32'h1);
    chk("s_done_act", 32'(active), 32'h0);
    tick();
    chk("s_done1", 32'(done), 32'h0);

    // simultaneous requests from reset
    busy_len = 3;
    do_reset();
    req = 4'b1111; req_data = 32'h4433_2211;
    grant_chk("rr0", 0, 8'h11);
    grant_chk("rr1", 1, 8'h22);
    grant_chk("rr2", 2, 8'h33);
    grant_chk("rr3", 3, 8'h44);
    grant_chk("rr4", 0, 8'h11);

    // wrap: last grant was 0
    req = 4'b1001;
    grant_chk("wr3", 3, 8'h44);
    grant_chk("wr0", 0, 8'h11);
    req = '0;
    wait_done(60, ok);
    chk("wr_done", 32'(ok), 32'h1);
    tick();

    // timeout with busy tied low
    model_en = 1'b0;
    req = 4'b0010; req_data = 32'h0000_5A00;
    grant_chk("to", 1, 8'h5A);
    req = '0;
    n = 2;   // grant cycle plus the one already checked
    flag = 1'b0;
    while (tx_start && n < 30) begin
      if (done) flag = 1'b1;
      tick();
      n++;
    end
    n--;     // loop counted the first low cycle
    chk("to_len", 32'(n), 32'd8);
    chk("to_err", 32'(timeout_err), 32'h1);
    chk("to_act", 32'(active), 32'h0);
    chk("to_nodone", 32'(flag | done), 32'h0);
    tick();
    chk("to_err1", 32'(timeout_err), 32'h0);
    model_en = 1'b1;
    // ptr advanced to 1: among {1,3} requester 3 wins
    req = 4'b1010; req_data = 32'h7700_6600;
    grant_chk("to_next", 3, 8'h77);
    req = '0;
    wait_done(60, ok);
    chk("to_next_done", 32'(ok), 32'h1);
    tick();

    // busy sampled on the expiry edge counts as success
    dly = 7;
    req = 4'b0001; req_data = 32'h0000_00C3;
    grant_chk("edge", 0, 8'hC3);
    req = '0;
    n = 2;
    flag = 1'b0;
    while (tx_start && n < 30) begin
      tick();
      n++;
    end
    n--;
    chk("edge_len", 32'(n), 32'd8);
    chk("edge_tmo", 32'(timeout_err), 32'h0);
    chk("edge_act", 32'(active), 32'h1);
    wait_done(60, ok);
    chk("edge_done", 32'(ok), 32'h1);
    tick();
    dly = 1;

    // reset mid-frame
    busy_len = 20;
    req = 4'b0001; req_data = 32'h0000_00E7;
    grant_chk("mr", 0, 8'hE7);
    req = '0;
    wait_txlow(10, ok);
    chk("mr_wait", 32'(ok), 32'h1);
    tick();
    rst = 1'b1;
    tick();
    chk_reset_vals("mr_rst");
    tick();
    chk("mr_done", 32'(done), 32'h0);
    rst = 1'b0;
    busy_len = 3;
    req = 4'b0010; req_data = 32'h0000_3C00;
    grant_chk("mr_after", 1, 8'h3C);
    req = '0;
    wait_done(60, ok);
    chk("mr_after_done", 32'(ok), 32'h1);
    tick();

    // late request during WAIT_DONE
    busy_len = 6;
    req = 4'b0001; req_data = 32'h0000_9600;
    req_data[7:0] = 8'h69;
    grant_chk("late0", 0, 8'h69);
    req = '0;
    wait_txlow(10, ok);
    chk("late_wait", 32'(ok), 32'h1);
    req = 4'b0010;
    flag = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      if (ack != 4'b0) flag = 1'b1;
      tick();
      n++;
    end
    chk("late_done", 32'(done), 32'h1);
    chk("late_noack", 32'(flag | (ack != 4'b0)), 32'h0);
    tick();
    chk("late_ack", 32'(ack), 32'h2);
    chk("late_data", 32'(tx_data), 32'h96);
    req = '0;
    wait_done(60, ok);
    chk("late_end", 32'(ok), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one RS232 `transmitter` between `NUM_REQ` byte producers. Each accepted byte is latched, presented on the transmitter's `data_in`, launched with a `tx_start` level handshake, and tracked through the transmitter's `busy` until the frame completes. Sits directly upstream of `transmitter`. Drives its `data_in`/`tx_start` and consumes its `busy`.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, from 2 to 16.
- `START_TIMEOUT`, default 8: maximum cycles `tx_start` is held without `tx_busy` rising.

Ports:
- `clk` in, 1 bit: single clock for all logic.
- `rst` in, 1 bit: reset, synchronous and active-high.
- `req` in, `NUM_REQ` bits: per-requester byte-valid. Held until the matching `ack`.
- `req_data` in, `8*NUM_REQ` bits: byte i is `req_data[8i+7:8i]`.
- `ack` out, `NUM_REQ` bits: one-hot, single-cycle pulse when byte i is latched.
- `tx_data` out, 8 bits: to transmitter `data_in`.
- `tx_start` out, 1 bit: to transmitter `tx_start`.
- `tx_busy` in, 1 bit: from transmitter `busy`.
- `active` out, 1 bit: high from grant until done or abort.
- `owner` out, `$clog2(NUM_REQ)` bits: index of the current or last granted requester.
- `done` out, 1 bit: single-cycle pulse when a frame completes.
- `timeout_err` out, 1 bit: single-cycle pulse when the start handshake is aborted.

## Operation
- States: IDLE, START, WAIT_DONE.
- **IDLE**
  - Wait for any `req` bit.
  - Choose the winner by round-robin. Priority begins at `(ptr+1) mod NUM_REQ` and wraps upward.
  - After reset `ptr = NUM_REQ-1`, so requester 0 has highest priority first.
  - On grant: latch `req_data[i]` into `tx_data`, pulse `ack[i]`, set `owner=i`, set `ptr=i`, set `active=1`, go to START.
- **START**
  - `tx_start=1`. `tx_data` held stable.
  - On `tx_busy==1`: drop `tx_start`, go to WAIT_DONE.
  - If `START_TIMEOUT` START cycles pass without `tx_busy`: drop `tx_start`, pulse `timeout_err`, clear `active`, return to IDLE. `ptr` still advances, so the byte is consumed (lost).
- **WAIT_DONE**
  - `tx_start=0`. `tx_data` held stable.
  - On `tx_busy==0`: pulse `done`, clear `active`, return to IDLE.
- Requests that arrive while not in IDLE are ignored until IDLE; nothing is queued internally.
- A requester deasserting `req` before its `ack` is legal; it simply loses the arbitration.
- The start-timeout counter is `$clog2(START_TIMEOUT+1)` bits wide, cleared on entry to START, saturating.

## Timing
- Reset values: `ack=0`, `tx_data=0x00`, `tx_start=0`, `active=0`, `owner=0`, `done=0`, `timeout_err=0`, `ptr=NUM_REQ-1`, state IDLE.
- Reset during START or WAIT_DONE aborts immediately: outputs go to reset values on the next edge, and no `done` or `timeout_err` pulse is produced.
- All outputs are registered.
- Grant latency:
  - `req` sampled high at edge k.
  - `ack`, `active`, `tx_data`, and `tx_start` are valid after edge k.
  - `ack` is low again after edge k+1.
- `tx_busy` sampled high at edge m: `tx_start` is low after edge m.
- `tx_busy` sampled low in WAIT_DONE at edge n: `done` is high for the cycle after edge n, with `active` low in that same cycle.
- Earliest next grant is at edge n+1. Back-to-back frames therefore have one idle cycle between `done` and the next `tx_start`.
- Timeout: `tx_start` is high for exactly `START_TIMEOUT` cycles, then `timeout_err` is high for 1 cycle.
- `tx_busy` arriving on the same edge as timeout expiry counts as success; the handshake is not aborted.

## Test plan
- **Single request:** reset, then `req=4'b0100`, `req_data[23:16]=0xA5`, with a transmitter model raising busy 1 cycle after start and holding it 100 cycles → `ack=4'b0100` for 1 cycle, `tx_data=0xA5`, `tx_start` high for 2 cycles, `owner=2`, `done` pulse after busy falls.
- **Simultaneous requests from reset:** `req=4'b1111` held → grants in order 0,1,2,3,0. Each `ack` is 1 cycle. `tx_data` matches each requester's byte.
- **Round-robin wrap:** after a grant to 3, `req=4'b1001` → next grant is 0, not 3. After a grant to 0 with `req=4'b1001` → next grant is 3.
- **Timeout:** `tx_busy` tied 0, `START_TIMEOUT=8` → `tx_start` high exactly 8 cycles, `timeout_err` 1-cycle pulse, no `done`, `ptr` advanced, next request served normally.
- **Reset mid-frame:** `rst=1` during WAIT_DONE → next cycle all outputs at reset values, no `done`. After `rst=0`, `req=4'b0010` is granted normally with `owner=1`.
- **Late request:** `req[1]` asserted during WAIT_DONE of requester 0 → no `ack[1]` until the cycle after `done`, then `ack[1]`.
